// File: rtl/scroll_background.sv
// scroll_background: scrolling banded playfield background looked up in a writable palette
// Optional feature macro: BG_CHECKER_EN (mode 2'b10 = checker bx^by; undefined -> mode 2'b10 acts as mode 2'b00)
// Ports:
//   clk, reset_n          pixel clock, synchronous active-low reset
//   pixel_x, pixel_y      current pixel coordinate from the sync generator
//   video_on              visible-area flag; outside it rgb is forced to 0
//   frame_tick            once-per-frame pulse that advances the scroll offset
//   scroll_en/dir/speed   offset update enable, direction (1 = decrease), step in pixels
//   mode                  00 vertical bands, 01 horizontal bands, 10 checker, 11 solid
//   pal_we/addr/data      palette write port
//   rgb                   registered background colour, one clock after the coordinate
//   scroll_off            current scroll offset
module scroll_background #(
  parameter int STRIPE_LOG2 = 7,
  parameter int NUM_BANDS = 8,
  parameter int RGB_W = 3,
  parameter logic [RGB_W-1:0] RESET_EVEN = 3'b010,
  parameter logic [RGB_W-1:0] RESET_ODD = 3'b000
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic [9:0]                   pixel_x,
  input  logic [9:0]                   pixel_y,
  input  logic                         video_on,
  input  logic                         frame_tick,
  input  logic                         scroll_en,
  input  logic                         scroll_dir,
  input  logic [3:0]                   scroll_speed,
  input  logic [1:0]                   mode,
  input  logic                         pal_we,
  input  logic [$clog2(NUM_BANDS)-1:0] pal_addr,
  input  logic [RGB_W-1:0]             pal_data,
  output logic [RGB_W-1:0]             rgb,
  output logic [9:0]                   scroll_off
);
  localparam int AW = $clog2(NUM_BANDS);
  logic [RGB_W-1:0] pal_q [NUM_BANDS];
  logic [RGB_W-1:0] rgb_q, rgb_d;
  logic [9:0] off_q, off_d, ex, ey;
  logic [AW-1:0] bx, by, idx;
  always_comb begin
    ex = pixel_x + off_q;
    ey = pixel_y + off_q;
    // band index keeps only the low AW bits so the pattern repeats every NUM_BANDS bands
    bx = AW'(ex >> STRIPE_LOG2);
    by = AW'(ey >> STRIPE_LOG2);
`ifdef BG_CHECKER_EN
    idx = mode == 2'b01 ? by : mode == 2'b11 ? '0 : mode == 2'b10 ? bx ^ by : bx;
`else
    idx = mode == 2'b01 ? by : mode == 2'b11 ? '0 : bx;
`endif
    rgb_d = video_on ? pal_q[idx] : '0;
    off_d = !(frame_tick && scroll_en) ? off_q :
            scroll_dir ? off_q - 10'(scroll_speed) : off_q + 10'(scroll_speed);
  end
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      rgb_q <= '0;
      off_q <= '0;
      for (int i = 0; i < NUM_BANDS; i++) pal_q[i] <= i[0] ? RESET_ODD : RESET_EVEN;
    end else begin
      rgb_q <= rgb_d;
      off_q <= off_d;
      if (pal_we) pal_q[pal_addr] <= pal_data;
    end
  end
  assign rgb = rgb_q;
  assign scroll_off = off_q;
endmodule

// File: tb/tb_scroll_background.sv
// tb_scroll_background: self-checking bench for scroll_background with an expected-colour queue
module tb_scroll_background;
  localparam int SL = 7, NB = 8, RW = 3, AW = 3;
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic [9:0] pixel_x = '0, pixel_y = '0;
  logic video_on = 1'b0, frame_tick = 1'b0, scroll_en = 1'b0, scroll_dir = 1'b0;
  logic [3:0] scroll_speed = '0;
  logic [1:0] mode = '0;
  logic pal_we = 1'b0;
  logic [AW-1:0] pal_addr = '0;
  logic [RW-1:0] pal_data = '0;
  logic [RW-1:0] rgb;
  logic [9:0] scroll_off;
  int checks = 0, errors = 0;
  logic [RW-1:0] exp_q[$];
  logic [RW-1:0] mdl_pal [NB];
  logic [9:0] mdl_off;

  scroll_background #(.STRIPE_LOG2(SL), .NUM_BANDS(NB), .RGB_W(RW),
                      .RESET_EVEN(3'b010), .RESET_ODD(3'b000)) dut (
    .clk(clk), .reset_n(reset_n), .pixel_x(pixel_x), .pixel_y(pixel_y), .video_on(video_on),
    .frame_tick(frame_tick), .scroll_en(scroll_en), .scroll_dir(scroll_dir),
    .scroll_speed(scroll_speed), .mode(mode), .pal_we(pal_we), .pal_addr(pal_addr),
    .pal_data(pal_data), .rgb(rgb), .scroll_off(scroll_off));

  always #5 clk = ~clk;

  function automatic logic [RW-1:0] model(input logic [9:0] x, y, input logic v, input logic [1:0] m);
    logic [9:0] ex, ey;
    logic [AW-1:0] bx, by, idx;
    ex = x + mdl_off;
    ey = y + mdl_off;
    bx = ex[SL+:AW];
    by = ey[SL+:AW];
    case (m)
      2'b01: idx = by;
      2'b11: idx = '0;
`ifdef BG_CHECKER_EN
      2'b10: idx = bx ^ by;
`endif
      default: idx = bx;
    endcase
    return v ? mdl_pal[idx] : '0;
  endfunction

  task automatic do_reset();
    reset_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
    mdl_off = '0;
    for (int i = 0; i < NB; i++) mdl_pal[i] = i[0] ? 3'b000 : 3'b010;
  endtask

  task automatic drive(input logic [9:0] x, y, input logic v, input logic [1:0] m, input logic [RW-1:0] e);
    pixel_x = x; pixel_y = y; video_on = v; mode = m;
    exp_q.push_back(e);
    @(posedge clk); #1;
  endtask

  task automatic tick(input logic en, dir, input logic [3:0] sp);
    frame_tick = 1'b1; scroll_en = en; scroll_dir = dir; scroll_speed = sp;
    @(posedge clk); #1;
    frame_tick = 1'b0;
    if (en) mdl_off = dir ? mdl_off - 10'(sp) : mdl_off + 10'(sp);
  endtask

  task automatic test_reset();
    logic [RW-1:0] e;
    video_on = 1'b1; pixel_x = '0; mode = 2'b00;
    reset_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (rgb !== 3'b000) begin errors++; $display("FAIL reset_rgb: got %b want 000", rgb); end
    checks++; if (scroll_off !== 10'd0) begin errors++; $display("FAIL reset_off: got %0d want 0", scroll_off); end
    do_reset();
    drive(10'd0, 10'd0, 1'b1, 2'b00, 3'b010);
    e = exp_q.pop_front(); checks++; if (rgb !== e) begin errors++; $display("FAIL reset_px0: got %b want %b", rgb, e); end
    drive(10'd128, 10'd0, 1'b1, 2'b00, 3'b000);
    e = exp_q.pop_front(); checks++; if (rgb !== e) begin errors++; $display("FAIL reset_px128: got %b want %b", rgb, e); end
    drive(10'd256, 10'd0, 1'b1, 2'b00, 3'b010);
    e = exp_q.pop_front(); checks++; if (rgb !== e) begin errors++; $display("FAIL reset_px256: got %b want %b", rgb, e); end
    drive(10'd0, 10'd0, 1'b0, 2'b00, 3'b000);
    e = exp_q.pop_front(); checks++; if (rgb !== e) begin errors++; $display("FAIL reset_blank: got %b want %b", rgb, e); end
  endtask

  task automatic test_scroll_wrap();
    repeat (205) tick(1'b1, 1'b0, 4'd5);
    checks++; if (scroll_off !== 10'd1) begin errors++; $display("FAIL wrap_up: got %0d want 1", scroll_off); end
    tick(1'b1, 1'b1, 4'd5);
    checks++; if (scroll_off !== 10'd1020) begin errors++; $display("FAIL wrap_down: got %0d want 1020", scroll_off); end
    repeat (3) tick(1'b0, 1'b0, 4'd9);
    checks++; if (scroll_off !== 10'd1020) begin errors++; $display("FAIL hold_en0: got %0d want 1020", scroll_off); end
    scroll_en = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (scroll_off !== 10'd1020) begin errors++; $display("FAIL hold_notick: got %0d want 1020", scroll_off); end
    repeat (8) tick(1'b1, 1'b0, 4'd13);
    scroll_en = 1'b0;
    checks++; if (scroll_off !== 10'd100) begin errors++; $display("FAIL off_100: got %0d want 100", scroll_off); end
  endtask

  task automatic test_scrolled_lookup();
    logic [RW-1:0] e;
    drive(10'd27, 10'd0, 1'b1, 2'b00, 3'b010);
    e = exp_q.pop_front(); checks++; if (rgb !== e) begin errors++; $display("FAIL scroll_px27: got %b want %b", rgb, e); end
    drive(10'd28, 10'd0, 1'b1, 2'b00, 3'b000);
    e = exp_q.pop_front(); checks++; if (rgb !== e) begin errors++; $display("FAIL scroll_px28: got %b want %b", rgb, e); end
  endtask

  task automatic test_palette_write();
    logic [RW-1:0] e;
    do_reset();
    checks++; if (scroll_off !== 10'd0) begin errors++; $display("FAIL pal_reset_off: got %0d want 0", scroll_off); end
    pal_we = 1'b1; pal_addr = 3'd1; pal_data = 3'b100;
    drive(10'd128, 10'd0, 1'b1, 2'b00, 3'b000);
    pal_we = 1'b0;
    e = exp_q.pop_front(); checks++; if (rgb !== e) begin errors++; $display("FAIL pal_same_cycle: got %b want %b", rgb, e); end
    drive(10'd128, 10'd0, 1'b1, 2'b00, 3'b100);
    e = exp_q.pop_front(); checks++; if (rgb !== e) begin errors++; $display("FAIL pal_next_cycle: got %b want %b", rgb, e); end
    pal_we = 1'b1; pal_data = 3'b111; frame_tick = 1'b1; scroll_en = 1'b1; scroll_dir = 1'b0; scroll_speed = 4'd7;
    do_reset();
    pal_we = 1'b0; frame_tick = 1'b0; scroll_en = 1'b0;
    checks++; if (scroll_off !== 10'd0) begin errors++; $display("FAIL reset_over_tick: got %0d want 0", scroll_off); end
    drive(10'd128, 10'd0, 1'b1, 2'b00, 3'b000);
    e = exp_q.pop_front(); checks++; if (rgb !== e) begin errors++; $display("FAIL pal_restored: got %b want %b", rgb, e); end
  endtask

  task automatic test_modes();
    logic [RW-1:0] e;
    drive(10'd0, 10'd130, 1'b1, 2'b01, 3'b000);
    e = exp_q.pop_front(); checks++; if (rgb !== e) begin errors++; $display("FAIL mode01_y130: got %b want %b", rgb, e); end
    drive(10'd128, 10'd256, 1'b1, 2'b01, 3'b010);
    e = exp_q.pop_front(); checks++; if (rgb !== e) begin errors++; $display("FAIL mode01_y256: got %b want %b", rgb, e); end
    drive(10'd128, 10'd128, 1'b1, 2'b11, 3'b010);
    e = exp_q.pop_front(); checks++; if (rgb !== e) begin errors++; $display("FAIL mode11_solid: got %b want %b", rgb, e); end
    drive(10'd128, 10'd0, 1'b1, 2'b00, 3'b000);
    e = exp_q.pop_front(); checks++; if (rgb !== e) begin errors++; $display("FAIL mode00_switch: got %b want %b", rgb, e); end
  endtask

  task automatic test_checker();
    logic [RW-1:0] e;
`ifdef BG_CHECKER_EN
    drive(10'd128, 10'd128, 1'b1, 2'b10, 3'b010);
`else
    drive(10'd128, 10'd128, 1'b1, 2'b10, 3'b000);
`endif
    e = exp_q.pop_front(); checks++; if (rgb !== e) begin errors++; $display("FAIL checker_128_128: got %b want %b", rgb, e); end
`ifdef BG_CHECKER_EN
    drive(10'd0, 10'd128, 1'b1, 2'b10, 3'b000);
`else
    drive(10'd0, 10'd128, 1'b1, 2'b10, 3'b010);
`endif
    e = exp_q.pop_front(); checks++; if (rgb !== e) begin errors++; $display("FAIL checker_0_128: got %b want %b", rgb, e); end
  endtask

  task automatic test_back_to_back();
    logic [RW-1:0] e;
    logic [9:0] x, y;
    logic [1:0] m;
    logic v;
    do_reset();
    for (int i = 0; i < NB; i++) begin
      pal_we = 1'b1; pal_addr = AW'(i); pal_data = RW'($urandom);
      @(posedge clk); #1;
      mdl_pal[i] = pal_data;
    end
    pal_we = 1'b0;
    for (int i = 0; i < 6; i++) tick(1'b1, 1'($urandom), 4'($urandom));
    checks++; if (scroll_off !== mdl_off) begin errors++; $display("FAIL b2b_off: got %0d want %0d", scroll_off, mdl_off); end
    for (int i = 0; i < 60; i++) begin
      x = 10'($urandom); y = 10'($urandom); m = 2'($urandom); v = ($urandom_range(0, 7) != 0);
      drive(x, y, v, m, model(x, y, v, m));
      e = exp_q.pop_front(); checks++;
      if (rgb !== e) begin errors++; $display("FAIL b2b_%0d: x=%0d y=%0d m=%b got %b want %b", i, x, y, m, rgb, e); end
    end
  endtask

  initial begin
    test_reset();
    test_scroll_wrap();
    test_scrolled_lookup();
    test_palette_write();
    test_modes();
    test_checker();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/scroll_background.md
# scroll_background

Parametrised, scrolling playfield background generator for the VGA graphics path. For every pixel it maps the (scrolled) pixel coordinate to a band index and looks that band up in a small writable palette. It produces a registered colour one clock after the pixel coordinate. It sits between the VGA sync generator (pixel_x, pixel_y, video_on, frame tick) and the object/colour multiplexer, and replaces the fixed two-colour stripe background.

## Interface
Parameters:
- STRIPE_LOG2, 7: band width/height is 2^STRIPE_LOG2 pixels; legal range 3..9.
- NUM_BANDS, 8: palette entries and distinct bands before the pattern repeats; power of two, 2..16.
- RGB_W, 3: colour width in bits.
- RESET_EVEN, 3'b010: reset value of even palette entries (green).
- RESET_ODD, 3'b000: reset value of odd palette entries (black).

Ports:
- clk  in  1  pixel clock.
- reset_n  in  1  synchronous, active-low reset.
- pixel_x  in  10  current pixel column.
- pixel_y  in  10  current pixel row.
- video_on  in  1  high inside the visible area.
- frame_tick  in  1  one-cycle pulse, once per frame, at start of vertical blank.
- scroll_en  in  1  enables offset update on frame_tick.
- scroll_dir  in  1  0 = offset increases, 1 = offset decreases.
- scroll_speed  in  4  pixels added/subtracted per frame.
- mode  in  2  00 vertical bands, 01 horizontal bands, 10 checker, 11 solid.
- pal_we  in  1  palette write strobe.
- pal_addr  in  log2(NUM_BANDS)  palette write address.
- pal_data  in  RGB_W  palette write data.
- rgb  out  RGB_W  registered background colour.
- scroll_off  out  10  current scroll offset (debug and sprite alignment).

## Operation
- Reset (reset_n low at a clk edge) sets the following:
  - rgb = 0 and scroll_off = 0.
  - Palette entry i = RESET_EVEN for even i and RESET_ODD for odd i.
  - Reset applied mid-frame takes priority over a simultaneous frame_tick or pal_we.
- Scroll offset: on a cycle with frame_tick=1 and scroll_en=1, scroll_off <= scroll_off ± scroll_speed.
  - Arithmetic is 10-bit modulo 1024; wrap is silent in both directions.
  - When frame_tick=0 or scroll_en=0, scroll_off holds.
- Effective coordinates:
  - ex = (pixel_x + scroll_off) mod 1024.
  - ey = (pixel_y + scroll_off) mod 1024.
  - bx = ex >> STRIPE_LOG2 and by = ey >> STRIPE_LOG2, each truncated to log2(NUM_BANDS) bits.
- Band index by mode:
  - 00: idx = bx.
  - 01: idx = by.
  - 10: idx = bx XOR by (see Configuration).
  - 11: idx = 0.
- Output: rgb <= video_on ? palette[idx] : 0, evaluated every clk.
- Palette write: when pal_we=1, palette[pal_addr] <= pal_data at the clk edge.
  - A lookup of the same entry in the same cycle returns the old value; the new value is visible from the next cycle.
- mode, scroll_dir and scroll_speed may change at any time.
  - mode takes effect on the next registered rgb.
  - scroll_dir and scroll_speed are sampled only on frame_tick.
- No state machine beyond the offset accumulator, palette registers and output register; no handshake.

## Timing
- Latency: pixel_x/pixel_y/video_on/mode sampled at edge N → rgb valid after edge N (1 cycle). The sync generator's delayed sync outputs must be aligned by one stage.
- The scroll_off update from a frame_tick sampled at edge N is visible on scroll_off after edge N, and in rgb from edge N+1.
- Palette write at edge N affects rgb from edge N+1.
- Throughput: one pixel per clk, no stalls.

## Configuration
- BG_CHECKER_EN defined: mode 10 produces the checker pattern idx = bx XOR by.
- BG_CHECKER_EN undefined:
  - The XOR logic is not compiled.
  - mode 10 behaves exactly as mode 00 (vertical bands).
  - All other modes are unchanged.

## Test plan
- Reset defaults: reset_n=0 for 2 clks, then mode=00, video_on=1, pixel_x=0 → rgb=3'b010; pixel_x=128 → 3'b000; pixel_x=256 → 3'b010; video_on=0 → rgb=0.
- Scroll wrap:
  - scroll_speed=5, scroll_en=1, scroll_dir=0, 205 frame_ticks → scroll_off=1025 mod 1024=1.
  - Then scroll_dir=1, 1 tick → 1020.
  - scroll_en=0 with ticks → scroll_off holds.
- Scrolled lookup: scroll_off=100, mode=00, pixel_x=27 → ex=127 → idx 0 → 3'b010; pixel_x=28 → ex=128 → idx 1 → 3'b000.
- Palette write:
  - pal_we=1, pal_addr=1, pal_data=3'b100 while pixel_x=128 is looked up → that cycle's rgb=3'b000, next cycle 3'b100.
  - Reset mid-test restores 3'b000.
- Modes:
  - mode=01 with pixel_y=130, pixel_x=0 → idx 1 → 3'b000.
  - mode=11 → always palette[0].
- Checker (run the bench with and without BG_CHECKER_EN): mode=10 at pixel_x=128, pixel_y=128 → idx 0 → 3'b010 with the macro; idx 1 → 3'b000 without it.
